srl16_cfg_loader: RTL
=====================

SRL16_CFG_LOADER -- requirements
Module: srl16_cfg_loader

Interface
REQ-001 Parameter NUM_SRL, default 1: number of cascaded 16-bit negative-edge SRLs driven by the loader; legal 1..4; word width W = 16*NUM_SRL.
REQ-002 Parameter MSB_FIRST, default 1: 1 = word bit W-1 shifted first, so it lands in bit 15 of the last SRL; 0 = bit 0 shifted first.
REQ-003 CLK  input  1  clock; all loader state on rising edge; the SRL chain consumes SRL_D/SRL_CE on the falling edge of the same CLK.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 IN_DATA  input  W  configuration word to shift into the chain.
REQ-006 IN_VALID  input  1  IN_DATA valid.
REQ-007 IN_READY  output  1  loader can accept a word.
REQ-008 ABORT  input  1  synchronous cancel of a load in progress.
REQ-009 SRL_D  output  1  serial data to the first SRL D input.
REQ-010 SRL_CE  output  1  shift enable to the SRL chain.
REQ-011 SRL_Q15  input  1  Q15 cascade output of the last SRL.
REQ-012 DONE  output  1  one-cycle pulse on load completion.
REQ-013 RB_DATA  output  W  previous chain contents (readback build only; constant 0 otherwise).
REQ-014 BUSY  output  1  high outside IDLE.

Function
REQ-015 FSM states: IDLE, SHIFT, FIN.
REQ-016 IDLE: IN_READY=1, SRL_CE=0; on IN_VALID=1, IN_DATA is captured, the bit counter is cleared, and the FSM goes to SHIFT.
REQ-017 SHIFT: SRL_CE=1, SRL_D = captured bit selected by the counter per MSB_FIRST; counter increments each cycle; at count W-1 the FSM goes to FIN.
REQ-018 FIN: DONE=1 for exactly one cycle, SRL_CE=0, IN_READY=0; next state IDLE.
REQ-019 Latency: word accepted at edge k; SRL_CE high for cycles k+1..k+W exactly; DONE high in cycle k+W+1; IN_READY high again from k+W+2.
REQ-020 SRL_D and SRL_CE are registered outputs; they are stable across the falling edge.
REQ-021 IN_VALID during SHIFT or FIN is ignored; it is not queued.
REQ-022 ABORT=1 in SHIFT: next state IDLE, no DONE, SRL chain contents undefined; ABORT in IDLE or FIN has no effect; ABORT and IN_VALID together in IDLE: the word is accepted.
REQ-023 The counter is ceil(log2(W)) bits wide and never wraps within a load.

Reset
REQ-024 RST_N low: state IDLE, counter 0, SRL_D=0, SRL_CE=0, DONE=0, RB_DATA=0, captured word 0; IN_READY=1 after release.
REQ-025 Reset mid-SHIFT: SRL_CE drops asynchronously; no DONE is produced.

Configuration
REQ-026 Macro SRL16_CFG_LOADER_READBACK_EN defined: SRL_Q15 is sampled at the accepting edge and at each SHIFT edge except the last (W samples), shifted into RB_DATA with the first sample as the MSB; RB_DATA is updated only at the FIN entry edge and holds until the next FIN.
REQ-027 Macro undefined: SRL_Q15 is unused, no readback registers exist, RB_DATA=0.

Structure
REQ-028 Shared package srl16_cfg_pkg holds the FSM state enum, SRL_DEPTH=16 and the maximum NUM_SRL.
REQ-029 One sub-module, srl16_cfg_shifter: the W-bit capture/shift register with bit select; the FSM and counter stay in the top module.

Verification
REQ-030 NUM_SRL=1, IN_DATA=16'hA5C3 accepted at edge 0 -> SRL_CE high cycles 1-16, SRL_D sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; DONE in cycle 17; behavioural SRL model holds 16'hA5C3.
REQ-031 Back-to-back IN_VALID held high with 16'h0001 then 16'hFFFF -> second word accepted only when IN_READY returns; model holds 16'hFFFF; exactly 2 DONE pulses.
REQ-032 ABORT pulsed in cycle 5 of a load -> SRL_CE low from cycle 6, no DONE, IN_READY=1 in cycle 6; next word loads correctly.
REQ-033 RST_N asserted mid-SHIFT (cycle 9) -> all outputs at reset values immediately; no DONE after release.
REQ-034 READBACK_EN, NUM_SRL=2, model preloaded 32'hDEADBEEF, load 32'h12345678 -> RB_DATA=32'hDEADBEEF in the DONE cycle; model holds 32'h12345678.
REQ-035 MSB_FIRST=0, 16'h8001 -> SRL_D first bit 1, bits 2-15 0, last bit 1; the model holds bit-reversed 16'h8001 (= 16'h8001).

Source files
------------

// File: rtl/srl16_cfg_pkg.sv
// Shared definitions for the SRL16 configuration loader: FSM states and chain geometry.
package srl16_cfg_pkg;

   localparam int SRL_DEPTH   = 16;
   localparam int MAX_NUM_SRL = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   function automatic int word_width(input int num_srl);
      return SRL_DEPTH * num_srl;
   endfunction

endpackage

// File: rtl/srl16_cfg_shifter.sv
// Capture register holding the configuration word, with an ordered bit select
// so the loader can fetch the n-th bit to be shifted regardless of bit order.
module srl16_cfg_shifter
   import srl16_cfg_pkg::*;
#(
   parameter int W         = SRL_DEPTH,
   parameter int MSB_FIRST = 1,
   parameter int CW        = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [W-1:0]  data,
   input  logic [CW-1:0] sel,
   output logic          bit_out
);

   logic [W-1:0]  word;
   logic [CW-1:0] idx;
   logic          in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= '0;
      end else if (load) begin
         word <= data;
      end
   end

   // sel counts shift order; word widths that are not a power of two leave unused sel codes
   always_comb begin
      idx      = (MSB_FIRST != 0) ? (CW'(W - 1) - sel) : sel;
      in_range = ({1'b0, sel} < (CW + 1)'(W));
      bit_out  = 1'b0;
      if (in_range) begin
         bit_out = word[idx];
      end
   end

endmodule

// File: rtl/srl16_cfg_loader.sv
// Serial loader for a cascade of negative-edge SRL16 primitives.
// Optional readback of the previous chain contents with SRL16_CFG_LOADER_READBACK_EN.
module srl16_cfg_loader
   import srl16_cfg_pkg::*;
#(
   parameter int NUM_SRL   = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic [SRL_DEPTH*NUM_SRL-1:0]   IN_DATA,
   input  logic                           IN_VALID,
   output logic                           IN_READY,
   input  logic                           ABORT,
   output logic                           SRL_D,
   output logic                           SRL_CE,
   input  logic                           SRL_Q15,
   output logic                           DONE,
   output logic [SRL_DEPTH*NUM_SRL-1:0]   RB_DATA,
   output logic                           BUSY
);

   localparam int W         = word_width(NUM_SRL);
   localparam int CW        = $clog2(W);
   localparam int FIRST_IDX = (MSB_FIRST != 0) ? (W - 1) : 0;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t        state;
   logic [CW-1:0] count;
   logic [CW-1:0] next_sel;
   logic          next_bit;
   logic          accept;
   logic          shift_last;

   assign accept     = (state == IDLE) && IN_VALID;
   assign shift_last = (state == SHIFT) && !ABORT && (count == LAST);
   assign next_sel   = count + 1'b1;
   assign IN_READY   = (state == IDLE);
   assign BUSY       = (state != IDLE);

   srl16_cfg_shifter #(
      .W         (W),
      .MSB_FIRST (MSB_FIRST),
      .CW        (CW)
   ) u_shifter (
      .clk     (CLK),
      .rst_n   (RST_N),
      .load    (accept),
      .data    (IN_DATA),
      .sel     (next_sel),
      .bit_out (next_bit)
   );

   // SRL_D is registered one bit ahead of the counter so it is stable over the falling edge
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         count  <= '0;
         SRL_D  <= 1'b0;
         SRL_CE <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  state  <= SHIFT;
                  count  <= '0;
                  SRL_CE <= 1'b1;
                  SRL_D  <= IN_DATA[FIRST_IDX];
               end
            end
            SHIFT: begin
               if (ABORT) begin
                  state  <= IDLE;
                  count  <= '0;
                  SRL_CE <= 1'b0;
                  SRL_D  <= 1'b0;
               end else if (count == LAST) begin
                  state  <= FIN;
                  SRL_CE <= 1'b0;
                  SRL_D  <= 1'b0;
                  DONE   <= 1'b1;
               end else begin
                  count <= next_sel;
                  SRL_D <= next_bit;
               end
            end
            FIN: begin
               state <= IDLE;
               count <= '0;
            end
            default: begin
               state  <= IDLE;
               count  <= '0;
               SRL_CE <= 1'b0;
               SRL_D  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SRL16_CFG_LOADER_READBACK_EN
   logic [W-1:0] rb_shift;

   // Q15 presents the old chain MSB-first, one bit per shift, so W samples rebuild the old word
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rb_shift <= '0;
         RB_DATA  <= '0;
      end else begin
         if (accept || ((state == SHIFT) && !ABORT && (count != LAST))) begin
            rb_shift <= {rb_shift[W-2:0], SRL_Q15};
         end
         if (shift_last) begin
            RB_DATA <= rb_shift;
         end
      end
   end
`else
   logic unused_q15;

   assign unused_q15 = SRL_Q15 ^ shift_last;
   assign RB_DATA    = '0;
`endif

endmodule
